divcfg_sequencer: RTL and testbench
===================================

Name: divcfg_sequencer

Overview:
- Configuration controller for the adjustable frequency divider. It drives the divider's LOAD_P, LOAD_D and PAR_LOAD inputs from a small programmable profile table of {period, duty, dwell}.
- Steps through profiles 0..last_idx, holding each one for `dwell` divider output periods. It optionally loops back to profile 0.
- It orders the two loads so the divider never rejects a period or ends up with duty >= period.
- Sits between the register/control interface and the divider instance, in the same clk domain.

Parameters:
- NPROF, 4, number of profile entries; a power of 2, >= 2.
- IDX_W, 2, index width, equal to log2(NPROF).
- DWELL_W, 8, width of the per-profile dwell count, in divider output periods.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  table write strobe.
- wr_idx  in  IDX_W  entry to write.
- wr_period  in  3  period to store.
- wr_duty  in  3  duty fraction to store.
- wr_dwell  in  DWELL_W  dwell count to store.
- last_idx  in  IDX_W  last profile in the sequence.
- loop  in  1  when 1, wrap to entry 0 after last_idx; when 0, stop after last_idx.
- start  in  1  pulse; begins the sequence at entry 0 (accepted only in IDLE).
- stop  in  1  abort the sequence; return to IDLE.
- div_out  in  1  divider output, used for dwell counting.
- load_p  out  1  to divider LOAD_P.
- load_d  out  1  to divider LOAD_D.
- par_load  out  3  to divider PAR_LOAD.
- busy  out  1  high in any state except IDLE.
- cur_idx  out  IDX_W  entry currently being applied.
- done  out  1  one-cycle pulse when a non-loop sequence completes.
- err  out  1  sticky; set when an invalid entry is skipped.

Behaviour:
Reset:
- State returns to IDLE.
- load_p, load_d, par_load, busy, cur_idx, done and err are all 0.
- Shadow period and shadow duty are 0 (these mirror the divider's reset values).
- Dwell counter and div_out edge register are 0.
- Table entries reset to {0,0,0}.

Table:
- Written on any clk where wr_en=1, in any state.
- FETCH reads the registered table contents, so a write in the same cycle as FETCH applies from the next fetch.

Entry validity:
- An entry is valid when period >= 2 and duty < period.

States:
- IDLE: when start=1 and stop=0, set cur_idx=0 and go to FETCH.
- FETCH (1 cycle):
  - Invalid entry: set err and go to ADVANCE.
  - Valid entry, period > shadow_duty: order is period-first.
  - Otherwise: order is duty-first.
  - Valid entries go to LOAD1.
- LOAD1 (1 cycle): assert the first load with par_load equal to that value, update its shadow, go to LOAD2.
- LOAD2 (1 cycle): assert the second load in the same way, clear the dwell counter, go to DWELL.
- DWELL:
  - Count rising edges of div_out (div_out=1 and its registered copy=0).
  - A dwell value of 0 is treated as 1.
  - When the count reaches dwell, go to ADVANCE.
- ADVANCE (1 cycle):
  - cur_idx < last_idx: increment cur_idx, go to FETCH.
  - cur_idx = last_idx and loop=1: set cur_idx=0, go to FETCH.
  - cur_idx = last_idx and loop=0: pulse done, go to IDLE.

Output rules:
- load_p and load_d are never high in the same cycle.
- par_load is 0 whenever neither load is asserted.
- Output latency: start in cycle N gives the first load in cycle N+2.

Load ordering:
- The ordering rule guarantees every intermediate divider state is legal (period >= 2, duty < period). This is what makes abort safe.

stop:
- Has priority over all other inputs.
- In any non-IDLE state, the next state is IDLE.
- No load is asserted in the stop cycle's successor.
- Shadow registers keep the last values actually loaded.
- cur_idx holds its value.
- done is not pulsed.

start while busy: ignored.

err: cleared only by reset.

All-invalid table with loop=1: the sequencer cycles FETCH/ADVANCE indefinitely with no loads; stop still exits.

Widths: the dwell counter is DWELL_W bits wide and saturates at compare; it does not wrap.

Decomposition:
- Shared package `divcfg_pkg` holds:
  - The state enum (IDLE, FETCH, LOAD1, LOAD2, DWELL, ADVANCE).
  - The profile struct {period[2:0], duty[2:0], dwell[DWELL_W-1:0]}.
  - The constant MIN_PERIOD=2.
- One sub-module: `divcfg_profile_rf`, the NPROF-entry table with one synchronous write port and one registered read port.

Test Plan:
1. Reset, then entry0={5,2,3}, last_idx=0, loop=0, start. Required:
   - LOAD1: load_p with par_load=5.
   - LOAD2: load_d with par_load=2.
   - After 3 div_out rising edges: done pulses and busy falls.
2. Entries {6,4,1} then {3,1,1}, shadow duty=4 on entering entry 1. Required: entry 1 is duty-first (load_d=1, then load_p=3); the divider period ends at 3.
3. Entry1={4,4,2} is invalid. Required: err=1, entry 1 is skipped with no loads, entry 2 is applied next.
4. loop=1, last_idx=1, 2 valid entries. Required: cur_idx sequence 0,1,0,1; done never asserts.
5. stop asserted during LOAD1 (period-first case). Required: busy=0 next cycle, no load_d issued, shadow period equals the new value.
6. wr_en to entry 0 in the same cycle as FETCH of entry 0. Required: the old values are loaded; the new values are loaded on the next loop pass.

Source files
------------

// File: rtl/divcfg_pkg.sv
// Shared types and constants for the divider configuration sequencer.
// The profile dwell field width must match the DWELL_W parameter of the users.
package divcfg_pkg;

  localparam int MIN_PERIOD   = 2;
  localparam int PROF_DWELL_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD1,
    LOAD2,
    DWELL,
    ADVANCE
  } state_t;

  typedef struct packed {
    logic [2:0]              period;
    logic [2:0]              duty;
    logic [PROF_DWELL_W-1:0] dwell;
  } profile_t;

  function automatic logic entry_valid(input profile_t e);
    return (e.period >= 3'(MIN_PERIOD)) && (e.duty < e.period);
  endfunction

endpackage

// File: rtl/divcfg_profile_rf.sv
// Profile table: one synchronous write port, one registered read port.
// The read register samples the table before a same-cycle write lands.
module divcfg_profile_rf
  import divcfg_pkg::*;
#(
  parameter int NPROF = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  profile_t         wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output profile_t         rd_data
);

  profile_t prof_mem [NPROF];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPROF; i++) prof_mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) prof_mem[wr_idx] <= wr_data;
      rd_data <= prof_mem[rd_idx];
    end
  end

endmodule

// File: rtl/divcfg_sequencer.sv
// Steps the frequency divider through a table of {period, duty, dwell} profiles,
// ordering the two loads so every intermediate divider setting stays legal.
module divcfg_sequencer
  import divcfg_pkg::*;
#(
  parameter int NPROF   = 4,
  parameter int IDX_W   = 2,
  parameter int DWELL_W = PROF_DWELL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [2:0]         wr_period,
  input  logic [2:0]         wr_duty,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic [IDX_W-1:0]   last_idx,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  input  logic               div_out,
  output logic               load_p,
  output logic               load_d,
  output logic [2:0]         par_load,
  output logic               busy,
  output logic [IDX_W-1:0]   cur_idx,
  output logic               done,
  output logic               err
);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  profile_t           wr_prof, rd_prof;
  logic               period_first;
  logic [2:0]         first_val, second_val;
  logic [DWELL_W-1:0] dwell_tgt, dwell_cnt;
  logic [2:0]         shadow_p, shadow_d;
  logic               div_q;
  logic               rise;
  logic               dwell_hit;

  assign wr_prof   = '{period: wr_period, duty: wr_duty, dwell: wr_dwell};
  assign rise      = div_out & ~div_q;
  assign dwell_hit = rise && (({1'b0, dwell_cnt} + 1'b1) >= {1'b0, dwell_tgt});
  assign busy      = (state != IDLE);

  // The read address follows the next index so FETCH sees the entry it is about to apply.
  divcfg_profile_rf #(
    .NPROF(NPROF),
    .IDX_W(IDX_W)
  ) u_rf (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .wr_data(wr_prof),
    .rd_idx (idx_nxt),
    .rd_data(rd_prof)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = cur_idx;
    load_p    = 1'b0;
    load_d    = 1'b0;
    par_load  = 3'd0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = FETCH;
          idx_nxt   = '0;
        end
      end
      FETCH:   state_nxt = entry_valid(rd_prof) ? LOAD1 : ADVANCE;
      LOAD1: begin
        state_nxt = LOAD2;
        par_load  = first_val;
        load_p    = period_first;
        load_d    = !period_first;
      end
      LOAD2: begin
        state_nxt = DWELL;
        par_load  = second_val;
        load_p    = !period_first;
        load_d    = period_first;
      end
      DWELL: begin
        if (dwell_hit) state_nxt = ADVANCE;
      end
      ADVANCE: begin
        if (cur_idx < last_idx) begin
          idx_nxt   = cur_idx + 1'b1;
          state_nxt = FETCH;
        end else if (loop) begin
          idx_nxt   = '0;
          state_nxt = FETCH;
        end else begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides everything except the load already on the wire this cycle.
    if (stop && state != IDLE) begin
      state_nxt = IDLE;
      idx_nxt   = cur_idx;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cur_idx      <= '0;
      err          <= 1'b0;
      period_first <= 1'b0;
      first_val    <= 3'd0;
      second_val   <= 3'd0;
      dwell_tgt    <= '0;
      dwell_cnt    <= '0;
      shadow_p     <= 3'd0;
      shadow_d     <= 3'd0;
      div_q        <= 1'b0;
    end else begin
      state   <= state_nxt;
      cur_idx <= idx_nxt;
      div_q   <= div_out;
      if (state == FETCH) begin
        if (!entry_valid(rd_prof) && !stop) err <= 1'b1;
        period_first <= (rd_prof.period > shadow_d);
        first_val    <= (rd_prof.period > shadow_d) ? rd_prof.period : rd_prof.duty;
        second_val   <= (rd_prof.period > shadow_d) ? rd_prof.duty : rd_prof.period;
        dwell_tgt    <= (rd_prof.dwell == '0) ? DWELL_W'(1) : rd_prof.dwell;
      end
      if (load_p) shadow_p <= par_load;
      if (load_d) shadow_d <= par_load;
      if (state == LOAD2) dwell_cnt <= '0;
      else if (state == DWELL && rise && dwell_cnt != dwell_tgt) dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == DWELL)
      assert (shadow_p >= 3'(MIN_PERIOD) && shadow_d < shadow_p);
  end

endmodule

// File: tb/tb_divcfg_sequencer.sv
// Randomized and directed bench for divcfg_sequencer, comparing the observed load/done
// event stream against a profile-level reference model.
module tb_divcfg_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_idx = '0;
  logic [2:0] wr_period = '0;
  logic [2:0] wr_duty = '0;
  logic [7:0] wr_dwell = '0;
  logic [1:0] last_idx = '0;
  logic       loop = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       div_out = 1'b0;
  logic       load_p, load_d, busy, done, err;
  logic [2:0] par_load;
  logic [1:0] cur_idx;

  divcfg_sequencer #(.NPROF(4), .IDX_W(2), .DWELL_W(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_period(wr_period),
    .wr_duty(wr_duty), .wr_dwell(wr_dwell), .last_idx(last_idx), .loop(loop),
    .start(start), .stop(stop), .div_out(div_out), .load_p(load_p), .load_d(load_d),
    .par_load(par_load), .busy(busy), .cur_idx(cur_idx), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Divider output: 8-cycle period, so at most one rising edge per profile gap.
  initial begin
    forever begin
      repeat (4) @(posedge clk);
      #1 div_out = ~div_out;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // kind: 0 = period load, 1 = duty load, 2 = done; rises = div_out edges since previous event
  typedef struct {int kind; int val; int idx; int rises;} ev_t;
  ev_t log_q[$];
  ev_t exp_q[$];

  int   rise_acc = 0;
  logic div_prev = 1'b0;
  int   dp = 0, dd = 0;

  always @(negedge clk) begin
    logic r;
    r = div_out && !div_prev;
    div_prev = div_out;
    if (reset) begin
      rise_acc = 0; dp = 0; dd = 0;
    end else begin
      check("load_excl", int'(load_p & load_d), 0);
      if (!load_p && !load_d) check("par_idle", int'(par_load), 0);
      if (load_p || load_d || done) begin
        log_q.push_back('{kind: load_p ? 0 : (load_d ? 1 : 2), val: int'(par_load),
                          idx: int'(cur_idx), rises: rise_acc});
        rise_acc = 0;
        if (load_p) dp = par_load;
        if (load_d) dd = par_load;
        if (load_p || load_d) check("div_legal", int'(dp >= 2 && dd < dp), 1);
      end else if (r) begin
        rise_acc++;
      end
    end
  end

  // Reference model: profile table plus the divider duty it believes is loaded.
  int mp[4], md[4], mw[4];
  int m_sd, m_prev;
  bit m_inv;

  task automatic model_reset();
    m_sd = 0; m_prev = -1; m_inv = 0;
    exp_q.delete();
  endtask

  task automatic model_pass(input int last);
    for (int i = 0; i <= last; i++) begin
      if (mp[i] >= 2 && md[i] < mp[i]) begin
        if (mp[i] > m_sd) begin
          exp_q.push_back('{kind: 0, val: mp[i], idx: i, rises: m_prev});
          exp_q.push_back('{kind: 1, val: md[i], idx: i, rises: 0});
        end else begin
          exp_q.push_back('{kind: 1, val: md[i], idx: i, rises: m_prev});
          exp_q.push_back('{kind: 0, val: mp[i], idx: i, rises: 0});
        end
        m_sd   = md[i];
        m_prev = (mw[i] == 0) ? 1 : mw[i];
      end else begin
        m_inv = 1;
      end
    end
  endtask

  task automatic model_done(input int last);
    exp_q.push_back('{kind: 2, val: 0, idx: last, rises: m_prev});
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1; start = 0; stop = 0; wr_en = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    log_q.delete();
    for (int i = 0; i < 4; i++) begin mp[i] = 0; md[i] = 0; mw[i] = 0; end
  endtask

  task automatic write_entry(input int idx, input int p, input int d, input int w);
    @(posedge clk); #1;
    wr_en = 1; wr_idx = 2'(idx); wr_period = 3'(p); wr_duty = 3'(d); wr_dwell = 8'(w);
    mp[idx] = p; md[idx] = d; mw[idx] = w;
    @(posedge clk); #1 wr_en = 0;
  endtask

  // Returns just after the edge that moved the DUT into FETCH.
  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic compare_log(input string tag);
    int n, t;
    n = exp_q.size();
    t = 0;
    while (log_q.size() < n && t < 4000) begin @(negedge clk); t++; end
    check({tag, "_count"}, int'(log_q.size() >= n), 1);
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      check($sformatf("%s_kind%0d", tag, i), log_q[i].kind, exp_q[i].kind);
      check($sformatf("%s_val%0d", tag, i), log_q[i].val, exp_q[i].val);
      check($sformatf("%s_idx%0d", tag, i), log_q[i].idx, exp_q[i].idx);
      if (exp_q[i].rises >= 0)
        check($sformatf("%s_dwell%0d", tag, i), log_q[i].rises, exp_q[i].rises);
    end
  endtask

  task automatic stop_now(input string tag, input int idx_exp);
    @(posedge clk); #1 stop = 1;
    @(posedge clk); #1 stop = 0;
    @(negedge clk);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_noload"}, int'(load_p | load_d), 0);
    check({tag, "_idx"}, int'(cur_idx), idx_exp);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_loadp", int'(load_p), 0);
    check("rst_loadd", int'(load_d), 0);
    check("rst_par", int'(par_load), 0);
    check("rst_idx", int'(cur_idx), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);

    // 1: single entry, latency, start ignored while busy
    write_entry(0, 5, 2, 3);
    last_idx = 0; loop = 0;
    model_reset(); model_pass(0); model_done(0);
    pulse_start();
    @(negedge clk);
    check("t1_lat_n1", int'(load_p), 0);
    @(negedge clk);
    check("t1_lat_n2", int'(load_p), 1);
    check("t1_lat_par", int'(par_load), 5);
    repeat (4) @(posedge clk);
    pulse_start();
    compare_log("t1");
    repeat (3) @(negedge clk);
    check("t1_nev", log_q.size(), exp_q.size());
    check("t1_busy", int'(busy), 0);
    check("t1_err", int'(err), 0);

    // 2: duty-first ordering
    do_reset();
    write_entry(0, 6, 4, 1);
    write_entry(1, 3, 1, 1);
    last_idx = 1; loop = 0;
    model_reset(); model_pass(1); model_done(1);
    pulse_start();
    compare_log("t2");
    check("t2_final_p", dp, 3);

    // 3: invalid entry skipped, err sticky
    do_reset();
    write_entry(0, 5, 2, 1);
    write_entry(1, 4, 4, 2);
    write_entry(2, 3, 1, 1);
    last_idx = 2; loop = 0;
    model_reset(); model_pass(2); model_done(2);
    pulse_start();
    compare_log("t3");
    check("t3_err", int'(err), int'(m_inv));
    repeat (5) @(posedge clk);
    check("t3_err_sticky", int'(err), 1);

    // 4: looping, no done
    do_reset();
    write_entry(0, 4, 1, 1);
    write_entry(1, 7, 5, 2);
    last_idx = 1; loop = 1;
    model_reset(); model_pass(1); model_pass(1);
    pulse_start();
    compare_log("t4");
    stop_now("t4_stop", 1);
    nd = 0;
    foreach (log_q[i]) if (log_q[i].kind == 2) nd++;
    check("t4_nodone", nd, 0);

    // 5: stop during LOAD1
    do_reset();
    write_entry(0, 5, 2, 2);
    last_idx = 0; loop = 0;
    pulse_start();
    @(posedge clk); #1 stop = 1;
    @(negedge clk);
    check("t5_loadp", int'(load_p), 1);
    check("t5_par", int'(par_load), 5);
    @(posedge clk); #1 stop = 0;
    @(negedge clk);
    check("t5_busy", int'(busy), 0);
    repeat (10) @(negedge clk);
    check("t5_nev", log_q.size(), 1);
    check("t5_shadow_p", dp, 5);

    // 6: write in the FETCH cycle takes effect on the next pass
    do_reset();
    write_entry(0, 5, 2, 1);
    last_idx = 0; loop = 1;
    model_reset(); model_pass(0);
    pulse_start();
    wr_en = 1; wr_idx = 0; wr_period = 3'd6; wr_duty = 3'd3; wr_dwell = 8'd1;
    @(posedge clk); #1 wr_en = 0;
    mp[0] = 6; md[0] = 3; mw[0] = 1;
    model_pass(0);
    compare_log("t6");
    stop_now("t6_stop", 0);

    // All-invalid table with loop: spins without loads until stopped
    do_reset();
    last_idx = 3; loop = 1;
    pulse_start();
    repeat (40) @(negedge clk);
    check("inv_busy", int'(busy), 1);
    check("inv_nev", log_q.size(), 0);
    check("inv_err", int'(err), 1);
    @(posedge clk); #1 stop = 1;
    @(posedge clk); #1 stop = 0;
    @(negedge clk);
    check("inv_stop_busy", int'(busy), 0);

    // Randomized tables, non-looping
    for (int it = 0; it < 20; it++) begin
      do_reset();
      for (int i = 0; i < 4; i++)
        write_entry(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)));
      last_idx = 2'($urandom_range(0, 3));
      loop = 0;
      model_reset(); model_pass(int'(last_idx)); model_done(int'(last_idx));
      pulse_start();
      compare_log($sformatf("rnd%0d", it));
      repeat (3) @(negedge clk);
      check($sformatf("rnd%0d_nev", it), log_q.size(), exp_q.size());
      check($sformatf("rnd%0d_err", it), int'(err), int'(m_inv));
      check($sformatf("rnd%0d_busy", it), int'(busy), 0);
      check($sformatf("rnd%0d_idx", it), int'(cur_idx), int'(last_idx));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
